// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// axi_pkg : shared response/state encodings and default widths for axi_bus_mux
// Revision 1.0
// ============================================================================
package axi_pkg;

  localparam int DEF_REQ_WIDTH = 2;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_LEN_W     = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5
  } mux_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_beat_counter.sv
`default_nettype none
// ============================================================================
// axi_beat_counter : burst beat counter, loads len and flags the final beat
// Revision 1.0
// ============================================================================
module axi_beat_counter
  import axi_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic             last
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (inc) begin
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  assign last = (cnt_q == len_q);

endmodule
`default_nettype wire

// File: rtl/axi_bus_mux.sv
`default_nettype none
// ============================================================================
// axi_bus_mux : routes the granted master's AXI channels to one slave port
// Optional LAST checking: define AXI_MUX_LAST_CHECK_EN.      Revision 1.0
// ============================================================================
module axi_bus_mux
  import axi_pkg::*;
#(
  parameter int REQ_WIDTH = DEF_REQ_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_WIDTH-1:0]        gnt,
  input  logic [REQ_WIDTH-1:0]        m_awvalid,
  output logic [REQ_WIDTH-1:0]        m_awready,
  input  logic [REQ_WIDTH*ADDR_W-1:0] m_awaddr,
  input  logic [REQ_WIDTH*LEN_W-1:0]  m_awlen,
  input  logic [REQ_WIDTH-1:0]        m_wvalid,
  output logic [REQ_WIDTH-1:0]        m_wready,
  input  logic [REQ_WIDTH*DATA_W-1:0] m_wdata,
  input  logic [REQ_WIDTH-1:0]        m_wlast,
  output logic [REQ_WIDTH-1:0]        m_bvalid,
  input  logic [REQ_WIDTH-1:0]        m_bready,
  output logic [1:0]                  m_bresp,
  input  logic [REQ_WIDTH-1:0]        m_arvalid,
  output logic [REQ_WIDTH-1:0]        m_arready,
  input  logic [REQ_WIDTH*ADDR_W-1:0] m_araddr,
  input  logic [REQ_WIDTH*LEN_W-1:0]  m_arlen,
  output logic [REQ_WIDTH-1:0]        m_rvalid,
  input  logic [REQ_WIDTH-1:0]        m_rready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [1:0]                  m_rresp,
  output logic                        m_rlast,
  output logic                        s_awvalid,
  input  logic                        s_awready,
  output logic [ADDR_W-1:0]           s_awaddr,
  output logic [LEN_W-1:0]            s_awlen,
  output logic                        s_wvalid,
  input  logic                        s_wready,
  output logic [DATA_W-1:0]           s_wdata,
  output logic                        s_wlast,
  input  logic                        s_bvalid,
  output logic                        s_bready,
  input  logic [1:0]                  s_bresp,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [ADDR_W-1:0]           s_araddr,
  output logic [LEN_W-1:0]            s_arlen,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [DATA_W-1:0]           s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rlast,
  output logic                        txn_done,
  output logic [1:0]                  txn_resp,
  output logic                        prot_err
);

  localparam int OWN_W = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1;

  mux_state_e       state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic             done_q, done_d;
  resp_e            resp_q, resp_d;

  logic             gnt_seen, gnt_multi, gnt_onehot;
  logic [OWN_W-1:0] gnt_idx;
  logic             cnt_load, cnt_inc, cnt_last;
  logic [LEN_W-1:0] cnt_len;

  // Multi-hot grants are rejected outright rather than resolved by priority.
  always_comb begin
    gnt_seen  = 1'b0;
    gnt_multi = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (gnt[i]) begin
        if (gnt_seen) gnt_multi = 1'b1;
        gnt_seen = 1'b1;
        gnt_idx  = OWN_W'(i);
      end
    end
    gnt_onehot = gnt_seen & ~gnt_multi;
  end

  assign s_awaddr = m_awaddr[int'(owner_q)*ADDR_W +: ADDR_W];
  assign s_awlen  = m_awlen [int'(owner_q)*LEN_W  +: LEN_W];
  assign s_wdata  = m_wdata [int'(owner_q)*DATA_W +: DATA_W];
  assign s_araddr = m_araddr[int'(owner_q)*ADDR_W +: ADDR_W];
  assign s_arlen  = m_arlen [int'(owner_q)*LEN_W  +: LEN_W];
  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;
  assign m_rlast  = s_rlast;
  assign m_bresp  = s_bresp;

`ifdef AXI_MUX_LAST_CHECK_EN
  logic prot_q, prot_d;
`else
  logic unused_wlast;
  assign unused_wlast = ^m_wlast;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    done_d    = 1'b0;
    resp_d    = resp_q;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_len   = '0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_arready = '0;
    m_rvalid  = '0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
`ifdef AXI_MUX_LAST_CHECK_EN
    prot_d    = prot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_onehot) begin
          owner_d = gnt_idx;
          if (m_awvalid[gnt_idx])      state_d = ST_WR_ADDR;
          else if (m_arvalid[gnt_idx]) state_d = ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: begin
        s_awvalid          = m_awvalid[owner_q];
        m_awready[owner_q] = s_awready;
        if (m_awvalid[owner_q] && s_awready) begin
          cnt_load = 1'b1;
          cnt_len  = s_awlen;
          state_d  = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        s_wvalid          = m_wvalid[owner_q];
        s_wlast           = cnt_last;
        m_wready[owner_q] = s_wready;
        if (m_wvalid[owner_q] && s_wready) begin
          cnt_inc = 1'b1;
`ifdef AXI_MUX_LAST_CHECK_EN
          if (m_wlast[owner_q] != cnt_last) prot_d = 1'b1;
`endif
          if (cnt_last) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        m_bvalid[owner_q] = s_bvalid;
        s_bready          = m_bready[owner_q];
        if (s_bvalid && m_bready[owner_q]) begin
          done_d  = 1'b1;
          resp_d  = resp_e'(s_bresp);
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        s_arvalid          = m_arvalid[owner_q];
        m_arready[owner_q] = s_arready;
        if (m_arvalid[owner_q] && s_arready) begin
          cnt_load = 1'b1;
          cnt_len  = s_arlen;
          state_d  = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        m_rvalid[owner_q] = s_rvalid;
        s_rready          = m_rready[owner_q];
        if (s_rvalid && m_rready[owner_q]) begin
          cnt_inc = 1'b1;
`ifdef AXI_MUX_LAST_CHECK_EN
          if (s_rlast && !cnt_last) prot_d = 1'b1;
`endif
          if (s_rlast) begin
            done_d  = 1'b1;
            resp_d  = resp_e'(s_rresp);
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      done_q  <= 1'b0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
    end
  end

`ifdef AXI_MUX_LAST_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prot_q <= 1'b0;
    else      prot_q <= prot_d;
  end
  assign prot_err = prot_q;
`else
  assign prot_err = 1'b0;
`endif

  assign txn_done = done_q;
  assign txn_resp = resp_q;

  axi_beat_counter #(
    .LEN_W (LEN_W)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .len  (cnt_len),
    .last (cnt_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_bus_mux.sv
`default_nettype none
// ============================================================================
// tb_axi_bus_mux : directed self-checking bench for axi_bus_mux
// Revision 1.0
// ============================================================================
module tb_axi_bus_mux;

  localparam int RW = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
`ifdef AXI_MUX_LAST_CHECK_EN
  localparam logic EXP_PROT = 1'b1;
`else
  localparam logic EXP_PROT = 1'b0;
`endif

  logic clk, rst;
  logic [RW-1:0] gnt;
  logic [RW-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [RW-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [RW*AW-1:0] m_awaddr, m_araddr;
  logic [RW*LW-1:0] m_awlen, m_arlen;
  logic [RW*DW-1:0] m_wdata;
  logic [1:0] m_bresp, m_rresp, s_bresp, s_rresp, txn_resp;
  logic [DW-1:0] m_rdata, s_wdata, s_rdata;
  logic m_rlast;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [LW-1:0] s_awlen, s_arlen;
  logic txn_done, prot_err;

  int n_checks = 0;
  int n_err    = 0;

  axi_bus_mux #(.REQ_WIDTH(RW), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .gnt(gnt),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .txn_done(txn_done), .txn_resp(txn_resp), .prot_err(prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; gnt = '0;
    m_awvalid = '0; m_awaddr = '0; m_awlen = '0;
    m_wvalid = '0; m_wdata = '0; m_wlast = '0; m_bready = '0;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    #2;
    chk("rst_done", 32'(txn_done), 32'd0);
    chk("rst_resp", 32'(txn_resp), 32'd0);
    chk("rst_prot", 32'(prot_err), 32'd0);
    chk("rst_svalid", {29'd0, s_awvalid, s_wvalid, s_arvalid}, 32'd0);
    chk("rst_mhs", {22'd0, m_awready, m_wready, m_arready, m_bvalid, m_rvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    step();

    // m0 write, len 3, slave always ready
    gnt = 2'b01; m_awvalid = 2'b01; m_awaddr[31:0] = 32'h100; m_awlen[3:0] = 4'd3;
    #1 chk("t1_idle_awvalid", 32'(s_awvalid), 32'd0);
    step();
    gnt = 2'b10;
    #1;
    chk("t1_awvalid", 32'(s_awvalid), 32'd1);
    chk("t1_awaddr", s_awaddr, 32'h100);
    chk("t1_awlen", 32'(s_awlen), 32'd3);
    chk("t1_awready", 32'(m_awready), 32'b01);
    step();
    m_awvalid = '0; m_wvalid = 2'b01;
    for (int b = 0; b < 4; b++) begin
      m_wdata[31:0] = 32'hA0 + 32'(b);
      m_wlast = (b == 3) ? 2'b01 : 2'b00;
      #1;
      chk($sformatf("t1_wlast_b%0d", b), 32'(s_wlast), (b == 3) ? 32'd1 : 32'd0);
      chk($sformatf("t1_wdata_b%0d", b), s_wdata, 32'hA0 + 32'(b));
      chk($sformatf("t1_wready_b%0d", b), 32'(m_wready), 32'b01);
      step();
    end
    m_wvalid = '0; m_wlast = '0; m_bready = 2'b01; s_bvalid = 1'b1; s_bresp = 2'b00;
    #1;
    chk("t1_wvalid_off", 32'(s_wvalid), 32'd0);
    chk("t1_bvalid", 32'(m_bvalid), 32'b01);
    chk("t1_bready", 32'(s_bready), 32'd1);
    chk("t1_done_early", 32'(txn_done), 32'd0);
    step();
    s_bvalid = 1'b0; m_bready = '0;
    #1;
    chk("t1_done", 32'(txn_done), 32'd1);
    chk("t1_resp", 32'(txn_resp), 32'd0);
    chk("t1_idle_bready", 32'(s_bready), 32'd0);
    step();
    chk("t1_done_pulse", 32'(txn_done), 32'd0);

    // m1 read, len 0, SLVERR
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h2000; m_arlen[7:4] = 4'd0;
    step();
    #1;
    chk("t2_arvalid", 32'(s_arvalid), 32'd1);
    chk("t2_araddr", s_araddr, 32'h2000);
    chk("t2_arready", 32'(m_arready), 32'b10);
    step();
    m_arvalid = '0; m_rready = 2'b11;
    s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; s_rresp = 2'b10; s_rlast = 1'b1;
    #1;
    chk("t2_rvalid", 32'(m_rvalid), 32'b10);
    chk("t2_rdata", m_rdata, 32'hDEADBEEF);
    chk("t2_rready", 32'(s_rready), 32'd1);
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    #1;
    chk("t2_done", 32'(txn_done), 32'd1);
    chk("t2_resp", 32'(txn_resp), 32'd2);
    chk("t2_rvalid_off", 32'(m_rvalid), 32'd0);

    // m0 aw and ar together: write first, read on the following grant
    gnt = 2'b01; m_awvalid = 2'b01; m_arvalid = 2'b01;
    m_awlen[3:0] = 4'd0; m_araddr[31:0] = 32'h300; m_arlen[3:0] = 4'd0;
    step();
    #1;
    chk("t3_awvalid", 32'(s_awvalid), 32'd1);
    chk("t3_arvalid_wait", 32'(s_arvalid), 32'd0);
    step();
    m_awvalid = '0; m_wvalid = 2'b01; m_wlast = 2'b01;
    #1 chk("t3_wlast", 32'(s_wlast), 32'd1);
    step();
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1'b1; s_bresp = 2'b01; m_bready = 2'b01;
    step();
    s_bvalid = 1'b0; m_bready = '0;
    #1;
    chk("t3_wdone", 32'(txn_done), 32'd1);
    chk("t3_wresp", 32'(txn_resp), 32'd1);
    chk("t3_idle_arvalid", 32'(s_arvalid), 32'd0);
    step();
    #1;
    chk("t3_arvalid", 32'(s_arvalid), 32'd1);
    chk("t3_araddr", s_araddr, 32'h300);
    step();
    m_arvalid = '0; m_rready = 2'b01; s_rvalid = 1'b1; s_rresp = 2'b00; s_rlast = 1'b1;
    #1 chk("t3_rvalid", 32'(m_rvalid), 32'b01);
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    #1;
    chk("t3_rdone", 32'(txn_done), 32'd1);
    chk("t3_rresp", 32'(txn_resp), 32'd0);

    // Multi-hot and empty grants stay idle
    gnt = 2'b11; m_awvalid = 2'b01;
    step();
    #1;
    chk("t4_multi_awvalid", 32'(s_awvalid), 32'd0);
    chk("t4_multi_awready", 32'(m_awready), 32'd0);
    step();
    #1 chk("t4_multi_awvalid2", 32'(s_awvalid), 32'd0);
    gnt = 2'b00;
    step();
    #1 chk("t4_zero_awvalid", 32'(s_awvalid), 32'd0);
    m_awvalid = '0;
    step();

    // Reset during beat 2 of a len-7 write
    gnt = 2'b01; m_awvalid = 2'b01; m_awaddr[31:0] = 32'h400; m_awlen[3:0] = 4'd7;
    step();
    step();
    m_awvalid = '0; m_wvalid = 2'b01; m_wlast = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t5_rst_wvalid", 32'(s_wvalid), 32'd0);
    chk("t5_rst_wready", 32'(m_wready), 32'd0);
    chk("t5_rst_done", 32'(txn_done), 32'd0);
    m_wvalid = '0;
    step();
    chk("t5_rst_done2", 32'(txn_done), 32'd0);
    rst = 1'b1;
    m_awvalid = 2'b01; m_awlen[3:0] = 4'd1;
    step();
    #1 chk("t5_fresh_awvalid", 32'(s_awvalid), 32'd1);
    step();
    m_awvalid = '0; m_wvalid = 2'b01; m_wlast = '0;
    #1 chk("t5_wlast_b0", 32'(s_wlast), 32'd0);
    step();
    m_wlast = 2'b01;
    #1 chk("t5_wlast_b1", 32'(s_wlast), 32'd1);
    step();
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 2'b01;
    step();
    s_bvalid = 1'b0; m_bready = '0;
    #1;
    chk("t5_done", 32'(txn_done), 32'd1);
    chk("t5_resp", 32'(txn_resp), 32'd0);
    chk("t5_prot_clean", 32'(prot_err), 32'd0);

    // Master wlast asserted early on beat 2 of a len-3 write
    gnt = 2'b01; m_awvalid = 2'b01; m_awlen[3:0] = 4'd3;
    step();
    step();
    m_awvalid = '0; m_wvalid = 2'b01;
    for (int b = 0; b < 4; b++) begin
      m_wlast = (b == 1) ? 2'b01 : 2'b00;
      step();
      if (b == 1) chk("t6_prot_set", 32'(prot_err), 32'(EXP_PROT));
    end
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 2'b01;
    step();
    s_bvalid = 1'b0; m_bready = '0;
    #1;
    chk("t6_done", 32'(txn_done), 32'd1);
    chk("t6_prot_after", 32'(prot_err), 32'(EXP_PROT));
    step();
    chk("t6_prot_sticky", 32'(prot_err), 32'(EXP_PROT));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_bus_mux.md
# axi_bus_mux

Downstream companion of the round-robin AXI arbiter: takes the arbiter's one-hot grant, latches the owning master, and routes that master's AW/W/AR channels to the single slave port while steering B/R back to it. It tracks burst beats and emits a one-cycle completion pulse with the response code, so the arbiter can re-enable arbitration. It never starts a second transaction until the current one has fully completed.

## Interface
- REQ_WIDTH, 2: number of masters; grant width.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- LEN_W, 4: burst length field width (beats = len+1).
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- gnt  in  REQ_WIDTH  one-hot grant from arbiter
- m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready  in  REQ_WIDTH each  per-master handshake inputs
- m_awready, m_wready, m_bvalid, m_arready, m_rvalid  out  REQ_WIDTH each  per-master handshake outputs
- m_awaddr, m_araddr  in  REQ_WIDTH*ADDR_W  packed per-master addresses (master i at slice i)
- m_awlen, m_arlen  in  REQ_WIDTH*LEN_W  packed burst lengths
- m_wdata  in  REQ_WIDTH*DATA_W; m_wlast  in  REQ_WIDTH
- m_rdata  out  DATA_W; m_rresp, m_bresp  out  2; m_rlast  out  1  (broadcast, qualified by m_rvalid/m_bvalid)
- s_aw*/s_w*/s_ar*  out, s_*ready  in: slave-side single AXI port, same fields, unpacked widths
- s_b*/s_r*  in, s_bready/s_rready  out: slave response channels
- txn_done  out  1  one-cycle pulse on transaction completion
- txn_resp  out  2  response of completed transaction, valid with txn_done
- prot_err  out  1  sticky LAST-mismatch flag

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: sample gnt; if exactly one bit set, latch owner index. Owner awvalid=1 -> WR_ADDR; else owner arvalid=1 -> RD_ADDR (write wins when both); else stay IDLE. Zero or multi-hot gnt: stay IDLE, latch nothing.
- WR_ADDR: s_aw* = owner AW fields; on s_awvalid&s_awready latch awlen into beat counter (cleared to 0) -> WR_DATA.
- WR_DATA: s_w* = owner W; each handshake increments counter; handshake with counter==len -> WR_RESP. s_wlast driven from counter (counter==len), not from master.
- WR_RESP: owner m_bvalid=s_bvalid, s_bready=owner bready; on handshake latch bresp -> IDLE.
- RD_ADDR/RD_DATA: mirror of write; RD_DATA leaves on R handshake with s_rlast=1; resp of final beat is txn_resp.
- Non-owner masters: all ready/valid outputs 0 at all times. In IDLE all slave valids and readies 0.
- Counter width LEN_W; wrap impossible since exit at counter==len.

## Timing
- Data/valid/ready paths are combinational muxes through latched owner: zero added latency per beat.
- txn_done/txn_resp registered: asserted the cycle after final B or last-R handshake, state already IDLE in that cycle.
- gnt sampled only in IDLE; earliest next transaction begins the cycle txn_done is high.
- gnt changes outside IDLE are ignored.
- Reset (any time, including mid-burst): state IDLE, owner 0, counter 0, txn_done 0, txn_resp 2'b00, prot_err 0; all valid/ready outputs 0 in the reset cycle. No partial completion pulse.

## Configuration
- AXI_MUX_LAST_CHECK_EN defined: in WR_DATA, master wlast != (counter==len) on a handshake sets prot_err; in RD_DATA, s_rlast=1 before counter==len sets prot_err and ends the read early (txn_done still pulses). prot_err clears only on reset.
- Undefined: master wlast ignored, s_rlast alone ends reads, prot_err tied 0.

## Structure
- Shared package axi_pkg: resp enum (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11), mux state enum, default widths.
- One sub-module: axi_beat_counter (load len, increment on handshake, last flag).

## Test plan
- gnt=01, m0 write addr 0x100 len 3, slave always ready -> 4 W beats, s_wlast on 4th only, bresp 00, txn_done one cycle later with txn_resp 00.
- gnt=10, m1 read len 0, slave rresp 10 -> single R beat to m1 only, txn_resp 10, m0 sees no rvalid.
- m0 awvalid and arvalid both 1 with gnt=01 -> write performed first, read waits for next grant.
- gnt=11 or 00 in IDLE -> no slave valid, state stays IDLE.
- Reset asserted during beat 2 of a len-7 write -> all outputs 0, IDLE, no txn_done; fresh write afterwards completes normally.
- With AXI_MUX_LAST_CHECK_EN: master wlast on beat 2 of len 3 -> prot_err=1, remains 1 after completion.
